reg_file_loader: RTL

REG_FILE_LOADER -- requirements
Module: reg_file_loader

---
 rtl/reg_file_loader_pkg.sv | 34 +++
 rtl/reg_file_loader_byte_packer.sv | 42 ++++
 rtl/reg_file_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/reg_file_loader_pkg.sv
// Shared definitions for the register-file loader: FSM state encoding,
// word/byte geometry and the register-file write payload.
package reg_file_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned MAX_REGS       = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // One register-file write port transaction.
  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_W-1:0]     data;
  } rf_wr_t;

  // Big-endian accumulation: earlier bytes move toward the MSBs.
  function automatic logic [WORD_W-1:0] shift_in_byte(
    input logic [WORD_W-1:0] word,
    input logic [BYTE_W-1:0] b
  );
    return {word[WORD_W-BYTE_W-1:0], b};
  endfunction

endpackage

// File: rtl/reg_file_loader_byte_packer.sv
// byte_packer: collects BYTES_PER_WORD bytes into one big-endian word.
// Ports:
//   clk, rst         clock, async active-high reset
//   i_clr            discard any partial word and restart the byte count
//   i_push           accept i_data this cycle
//   i_data           byte to shift in
//   o_word           packed word (stable once the last byte is in)
//   o_word_valid_c   high in the cycle the final byte of a word is pushed
module byte_packer
  import reg_file_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid_c
);

  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_cnt;

  // Shift register plus byte counter; counter wraps to 0 after the last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_push) begin
      r_word <= shift_in_byte(r_word, i_data);
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign o_word         = r_word;
  // Combinational so the loader can enter WRITE with no bubble.
  assign o_word_valid_c = i_push && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/reg_file_loader.sv
// reg_file_loader: streams bytes into 32-bit words and writes them to
// consecutive register-file entries starting at r0.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           begin a load (honoured only when not busy)
//   abort           cancel an active load
//   in_valid/in_data/in_ready   byte-stream handshake
//   rf_rd/rf_reg_write/rf_write_data   register-file write port
//   busy            load in progress (COLLECT or WRITE)
//   done            last load completed
module reg_file_loader
  import reg_file_loader_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter bit          SKIP_R0  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [BYTE_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic                  rf_reg_write,
  output logic [WORD_W-1:0]     rf_write_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  generate
    if (NUM_REGS < 1 || NUM_REGS > MAX_REGS) begin : g_bad_num_regs
      $error("reg_file_loader: NUM_REGS must be in 1..%0d", MAX_REGS);
    end
  endgenerate

  state_t                r_state;
  state_t                w_state_n;
  logic [REG_ADDR_W-1:0] r_idx;
  logic [REG_ADDR_W-1:0] w_idx_n;
  logic                  w_clr;
  logic                  w_push;
  logic                  w_in_ready;
  logic                  w_word_valid;
  logic [WORD_W-1:0]     w_word;
  rf_wr_t                w_rf;

  byte_packer u_byte_packer (
    .clk            (clk),
    .rst            (rst),
    .i_clr          (w_clr),
    .i_push         (w_push),
    .i_data         (in_data),
    .o_word         (w_word),
    .o_word_valid_c (w_word_valid)
  );

  // State and register index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
    end
  end

  // Next state and write-port outputs; abort wins over any transfer or write.
  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_clr      = 1'b0;
    w_push     = 1'b0;
    w_in_ready = 1'b0;
    w_rf       = '0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_n = ST_COLLECT;
          w_idx_n   = '0;
          w_clr     = 1'b1;
        end
      end

      ST_COLLECT: begin
        w_in_ready = !abort;
        w_push     = in_valid && !abort;
        if (abort) begin
          w_state_n = ST_IDLE;
          w_clr     = 1'b1;
        end else if (w_word_valid) begin
          w_state_n = ST_WRITE;
        end
      end

      ST_WRITE: begin
        w_rf.rd        = r_idx;
        w_rf.data      = w_word;
        w_rf.reg_write = !abort && !(SKIP_R0 && (r_idx == '0));
        if (abort) begin
          w_state_n = ST_IDLE;
          w_clr     = 1'b1;
        end else if (r_idx == LAST_IDX) begin
          w_state_n = ST_DONE;
        end else begin
          w_idx_n   = r_idx + REG_ADDR_W'(1);
          w_state_n = ST_COLLECT;
        end
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign in_ready      = w_in_ready;
  assign rf_rd         = w_rf.rd;
  assign rf_reg_write  = w_rf.reg_write;
  assign rf_write_data = w_rf.data;
  assign busy          = (r_state == ST_COLLECT) || (r_state == ST_WRITE);
  assign done          = (r_state == ST_DONE);

endmodule
